// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-side controller for the combinational ALU.
// Accepts micro-ops over valid/ready, reads a small register file, drives
// the ALU for one cycle, captures its result and flags, then writes back.
// Optional build macro: ALU_SEQ_PERF_EN adds the op_count output, a
// saturating count of commands completed without error.
module alu_op_sequencer #(
   parameter int unsigned BUS_WIDTH = 16,
   parameter int unsigned ADDR_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [3:0]           cmd_opcode,
   input  logic [ADDR_W-1:0]    cmd_dst,
   input  logic [ADDR_W-1:0]    cmd_src_a,
   input  logic [ADDR_W-1:0]    cmd_src_b,
   input  logic [BUS_WIDTH-1:0] cmd_imm,
   output logic [BUS_WIDTH-1:0] alu_a,
   output logic [BUS_WIDTH-1:0] alu_b,
   output logic                 alu_carry_in,
   output logic [3:0]           alu_opcode,
   input  logic [BUS_WIDTH-1:0] alu_y,
   input  logic                 alu_carry_out,
   input  logic                 alu_borrow,
   input  logic                 alu_zero,
   input  logic                 alu_parity,
   input  logic                 alu_invalid_op,
   output logic                 done,
   output logic                 err,
   output logic                 err_sticky,
   output logic                 flag_c,
   output logic                 flag_z,
   output logic                 flag_p,
`ifdef ALU_SEQ_PERF_EN
   output logic [15:0]          op_count,
`endif
   input  logic [ADDR_W-1:0]    rd_sel,
   output logic [BUS_WIDTH-1:0] rd_data
);

   localparam int unsigned NUM_REGS = 32'(1) << ADDR_W;

   localparam logic [3:0] OP_LOAD = 4'd0;
   localparam logic [3:0] OP_ADC  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_INC  = 4'd4;
   localparam logic [3:0] OP_DEC  = 4'd5;
   localparam logic [3:0] OP_MAX  = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [3:0]           op_q,      op_d;
   logic [ADDR_W-1:0]    dst_q,     dst_d;
   logic [BUS_WIDTH-1:0] imm_q,     imm_d;
   logic [BUS_WIDTH-1:0] alu_a_q,   alu_a_d;
   logic [BUS_WIDTH-1:0] alu_b_q,   alu_b_d;
   logic                 alu_cin_q, alu_cin_d;
   logic [3:0]           alu_op_q,  alu_op_d;
   logic [BUS_WIDTH-1:0] res_y_q,   res_y_d;
   logic                 res_co_q,  res_co_d;
   logic                 res_bo_q,  res_bo_d;
   logic                 res_z_q,   res_z_d;
   logic                 res_p_q,   res_p_d;
   logic                 res_inv_q, res_inv_d;
   logic [BUS_WIDTH-1:0] rf_q [NUM_REGS];
   logic [BUS_WIDTH-1:0] rf_d [NUM_REGS];
   logic                 flag_c_q,  flag_c_d;
   logic                 flag_z_q,  flag_z_d;
   logic                 flag_p_q,  flag_p_d;
   logic                 done_q,    done_d;
   logic                 err_q,     err_d;
   logic                 sticky_q,  sticky_d;
`ifdef ALU_SEQ_PERF_EN
   logic [15:0]          op_count_q, op_count_d;
`endif

   logic accept;

   assign cmd_ready = (state_q == S_IDLE) && rst_n;
   assign accept    = cmd_valid && cmd_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: IDLE -> EXEC -> WB -> IDLE, one cycle each after accept
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath/output next values: operand fetch, ALU capture, write-back
   always_comb begin
      op_d      = op_q;
      dst_d     = dst_q;
      imm_d     = imm_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_cin_d = alu_cin_q;
      alu_op_d  = alu_op_q;
      res_y_d   = res_y_q;
      res_co_d  = res_co_q;
      res_bo_d  = res_bo_q;
      res_z_d   = res_z_q;
      res_p_d   = res_p_q;
      res_inv_d = res_inv_q;
      rf_d      = rf_q;
      flag_c_d  = flag_c_q;
      flag_z_d  = flag_z_q;
      flag_p_d  = flag_p_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      sticky_d  = sticky_q;
`ifdef ALU_SEQ_PERF_EN
      op_count_d = op_count_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d      = cmd_opcode;
               dst_d     = cmd_dst;
               imm_d     = cmd_imm;
               // Sources are read here, so dst == src sees the old value
               alu_a_d   = rf_q[cmd_src_a];
               alu_b_d   = rf_q[cmd_src_b];
               alu_cin_d = flag_c_q;
               alu_op_d  = cmd_opcode;
            end
         end
         S_EXEC: begin
            res_y_d   = alu_y;
            res_co_d  = alu_carry_out;
            res_bo_d  = alu_borrow;
            res_z_d   = alu_zero;
            res_p_d   = alu_parity;
            res_inv_d = alu_invalid_op;
            // ALU bus is driven only while executing
            alu_a_d   = '0;
            alu_b_d   = '0;
            alu_cin_d = 1'b0;
            alu_op_d  = 4'd0;
         end
         S_WB: begin
            done_d = 1'b1;
            if (op_q == OP_LOAD) begin
               rf_d[dst_q] = imm_q;
            end else if ((op_q > OP_MAX) || res_inv_q) begin
               err_d    = 1'b1;
               sticky_d = 1'b1;
            end else begin
               rf_d[dst_q] = res_y_q;
               flag_z_d    = res_z_q;
               flag_p_d    = res_p_q;
               if ((op_q == OP_ADC) || (op_q == OP_INC) || (op_q == OP_DEC))
                  flag_c_d = res_co_q;
               else if (op_q == OP_SUB)
                  flag_c_d = res_bo_q;
            end
`ifdef ALU_SEQ_PERF_EN
            if (!err_d && (op_count_q != 16'hFFFF))
               op_count_d = op_count_q + 16'd1;
`endif
         end
         default: ;
      endcase
   end

   // Datapath registers; reset drops any in-flight command
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= 4'd0;
         dst_q     <= '0;
         imm_q     <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_cin_q <= 1'b0;
         alu_op_q  <= 4'd0;
         res_y_q   <= '0;
         res_co_q  <= 1'b0;
         res_bo_q  <= 1'b0;
         res_z_q   <= 1'b0;
         res_p_q   <= 1'b0;
         res_inv_q <= 1'b0;
         for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
         flag_c_q  <= 1'b0;
         flag_z_q  <= 1'b0;
         flag_p_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         sticky_q  <= 1'b0;
`ifdef ALU_SEQ_PERF_EN
         op_count_q <= 16'd0;
`endif
      end else begin
         op_q      <= op_d;
         dst_q     <= dst_d;
         imm_q     <= imm_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_cin_q <= alu_cin_d;
         alu_op_q  <= alu_op_d;
         res_y_q   <= res_y_d;
         res_co_q  <= res_co_d;
         res_bo_q  <= res_bo_d;
         res_z_q   <= res_z_d;
         res_p_q   <= res_p_d;
         res_inv_q <= res_inv_d;
         rf_q      <= rf_d;
         flag_c_q  <= flag_c_d;
         flag_z_q  <= flag_z_d;
         flag_p_q  <= flag_p_d;
         done_q    <= done_d;
         err_q     <= err_d;
         sticky_q  <= sticky_d;
`ifdef ALU_SEQ_PERF_EN
         op_count_q <= op_count_d;
`endif
      end
   end

   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_carry_in = alu_cin_q;
   assign alu_opcode   = alu_op_q;
   assign done         = done_q;
   assign err          = err_q;
   assign err_sticky   = sticky_q;
   assign flag_c       = flag_c_q;
   assign flag_z       = flag_z_q;
   assign flag_p       = flag_p_q;
   assign rd_data      = rf_q[rd_sel];
`ifdef ALU_SEQ_PERF_EN
   assign op_count     = op_count_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed commands, a behavioural ALU,
// and a scoreboard monitor that checks every done pulse.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_opcode;
   logic [1:0]  cmd_dst, cmd_src_a, cmd_src_b;
   logic [15:0] cmd_imm;
   logic [15:0] alu_a, alu_b, alu_y;
   logic        alu_carry_in, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
   logic [3:0]  alu_opcode;
   logic        done, err, err_sticky, flag_c, flag_z, flag_p;
   logic [1:0]  rd_sel, rd_sel_main, rd_sel_mon;
   logic        use_main;
   logic [15:0] rd_data;
`ifdef ALU_SEQ_PERF_EN
   logic [15:0] op_count;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          cyc;
      logic [1:0]  dst;
      logic [15:0] val;
      logic        e, c, z, p;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rd_sel = use_main ? rd_sel_main : rd_sel_mon;

   alu_op_sequencer #(.BUS_WIDTH(16), .ADDR_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in), .alu_opcode(alu_opcode),
      .alu_y(alu_y), .alu_carry_out(alu_carry_out), .alu_borrow(alu_borrow),
      .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_invalid_op(alu_invalid_op),
      .done(done), .err(err), .err_sticky(err_sticky),
      .flag_c(flag_c), .flag_z(flag_z), .flag_p(flag_p),
`ifdef ALU_SEQ_PERF_EN
      .op_count(op_count),
`endif
      .rd_sel(rd_sel), .rd_data(rd_data)
   );

   // Behavioural stand-in for the team ALU
   logic [16:0] t;
   always_comb begin
      t              = 17'd0;
      alu_borrow     = 1'b0;
      alu_invalid_op = 1'b0;
      case (alu_opcode)
         4'd1: t = 17'(alu_a) + 17'(alu_b);
         4'd2: t = 17'(alu_a) + 17'(alu_b) + 17'(alu_carry_in);
         4'd3: begin t = 17'(alu_a) - 17'(alu_b); alu_borrow = t[16]; t[16] = 1'b0; end
         4'd4: t = 17'(alu_a) + 17'd1;
         4'd5: t = 17'(alu_a) - 17'd1;
         4'd6: t = 17'(alu_a & alu_b);
         4'd7: t = 17'(~alu_a);
         4'd8: t = 17'({alu_a[14:0], alu_a[15]});
         4'd9: t = 17'({alu_a[0], alu_a[15:1]});
         4'd0: t = 17'd0;
         default: alu_invalid_op = 1'b1;
      endcase
      alu_y         = t[15:0];
      alu_carry_out = t[16];
      alu_zero      = (t[15:0] == 16'd0);
      alu_parity    = ^t[15:0];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse pops one expectation
   initial begin
      exp_t e;
      rd_sel_mon = 2'd0;
      forever begin
         @(negedge clk);
         if (err && !done) begin
            errors++;
            $display("FAIL err_without_done: err=1 done=0 (cycle %0d)", cyc);
         end
         if (done) begin
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: done=1 with no command outstanding (cycle %0d)", cyc);
            end else begin
               e = sbq.pop_front();
               chk("done_latency", 32'(cyc), 32'(e.cyc));
               chk("err", 32'(err), 32'(e.e));
               chk("flag_c", 32'(flag_c), 32'(e.c));
               chk("flag_z", 32'(flag_z), 32'(e.z));
               chk("flag_p", 32'(flag_p), 32'(e.p));
               rd_sel_mon = e.dst;
               #1;
               if (!use_main) chk("rf_dst", 32'(rd_data), 32'(e.val));
            end
         end
      end
   end

   // Issue one command; expected register value and flags after completion
   task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [15:0] imm, input logic [15:0] val,
                        input logic e, input logic c, input logic z, input logic p);
      exp_t x;
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_dst    = dst;
      cmd_src_a  = sa;
      cmd_src_b  = sb;
      cmd_imm    = imm;
      chk("ready_idle", 32'(cmd_ready), 32'd1);
      x.cyc = cyc + 3; x.dst = dst; x.val = val; x.e = e; x.c = c; x.z = z; x.p = p;
      sbq.push_back(x);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("ready_exec", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("ready_wb", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("ready_after", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_dst = 2'd0;
      cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_imm = 16'd0;
      use_main = 1'b1; rd_sel_main = 2'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sticky", 32'(err_sticky), 32'd0);
      chk("rst_flags", 32'({flag_c, flag_z, flag_p}), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      for (int i = 0; i < 4; i++) begin
         rd_sel_main = 2'(i); #1;
         chk("rst_rf", 32'(rd_data), 32'd0);
      end
      use_main = 1'b0;

      // Basic load/add
      issue(4'd0, 2'd0, 2'd0, 2'd0, 16'h0005, 16'h0005, 0, 0, 0, 0);
      issue(4'd0, 2'd1, 2'd0, 2'd0, 16'h0003, 16'h0003, 0, 0, 0, 0);
      issue(4'd1, 2'd2, 2'd0, 2'd1, 16'h0000, 16'h0008, 0, 0, 0, 1);
      // ADC carry chain
      issue(4'd0, 2'd0, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 1);
      issue(4'd0, 2'd1, 2'd0, 2'd0, 16'h0001, 16'h0001, 0, 0, 0, 1);
      issue(4'd2, 2'd2, 2'd0, 2'd1, 16'h0000, 16'h0000, 0, 1, 1, 0);
      issue(4'd2, 2'd3, 2'd1, 2'd1, 16'h0000, 16'h0003, 0, 0, 0, 0);
      // SUB borrow, AND keeps C
      issue(4'd0, 2'd0, 2'd0, 2'd0, 16'h0002, 16'h0002, 0, 0, 0, 0);
      issue(4'd3, 2'd2, 2'd1, 2'd0, 16'h0000, 16'hFFFF, 0, 1, 0, 0);
      issue(4'd6, 2'd3, 2'd0, 2'd1, 16'h0000, 16'h0000, 0, 1, 1, 0);
      // Rotates, NOT with dst==src, INC wrap
      issue(4'd0, 2'd0, 2'd0, 2'd0, 16'h8001, 16'h8001, 0, 1, 1, 0);
      issue(4'd8, 2'd1, 2'd0, 2'd0, 16'h0000, 16'h0003, 0, 1, 0, 0);
      issue(4'd9, 2'd2, 2'd0, 2'd0, 16'h0000, 16'hC000, 0, 1, 0, 0);
      issue(4'd0, 2'd3, 2'd0, 2'd0, 16'h00FF, 16'h00FF, 0, 1, 0, 0);
      issue(4'd7, 2'd3, 2'd3, 2'd3, 16'h0000, 16'hFF00, 0, 1, 0, 0);
      issue(4'd0, 2'd1, 2'd0, 2'd0, 16'h0000, 16'h0000, 0, 1, 0, 0);
      issue(4'd2, 2'd2, 2'd1, 2'd1, 16'h0000, 16'h0001, 0, 0, 0, 1);
      issue(4'd0, 2'd0, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 1);
      issue(4'd4, 2'd1, 2'd0, 2'd0, 16'h0000, 16'h0000, 0, 1, 1, 0);
      // Illegal opcode then a normal ADD
      chk("sticky_before", 32'(err_sticky), 32'd0);
      issue(4'd12, 2'd0, 2'd1, 2'd1, 16'h1234, 16'hFFFF, 1, 1, 1, 0);
      chk("sticky_set", 32'(err_sticky), 32'd1);
      issue(4'd1, 2'd2, 2'd0, 2'd0, 16'h0000, 16'hFFFE, 0, 1, 0, 1);
      chk("sticky_hold", 32'(err_sticky), 32'd1);

      // Reset during EXEC drops the command
      @(negedge clk);
      cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_dst = 2'd0; cmd_imm = 16'h1234;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rstx_ready", 32'(cmd_ready), 32'd0);
      chk("rstx_alu_op", 32'({alu_opcode, alu_a}), 32'd0);
      chk("rstx_sticky", 32'(err_sticky), 32'd0);
      chk("rstx_flags", 32'({flag_c, flag_z, flag_p}), 32'd0);
      use_main = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rd_sel_main = 2'(i); #1;
         chk("rstx_rf", 32'(rd_data), 32'd0);
      end
      use_main = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rstx_ready_after", 32'(cmd_ready), 32'd1);
      repeat (3) @(negedge clk);
      issue(4'd0, 2'd1, 2'd0, 2'd0, 16'h0007, 16'h0007, 0, 0, 0, 0);
      issue(4'd1, 2'd2, 2'd1, 2'd1, 16'h0000, 16'h000E, 0, 0, 0, 1);

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
